modn_counter_param: RTL and testbench
=====================================

# modn_counter_param

Parametrised synchronous mod-N counter, successor to the fixed count-to-5 ripple counter. Counts 0..M-1 up or down under enable. M is selected at run time, with the parameter as the default. Provides a registered wrap pulse and a saturating wrap tally. It is the shared timebase and divider block for downstream sequencers.

## Interface
- WIDTH, 3: counter width in bits; must be ≥ 1.
- MODULUS, 5: default modulus used when mod_val = 0; must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.
- WRAP_W, 8: width of the wrap tally.
- clk  in  1  single clock; all state changes on its rising edge.
- clr  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- mod_val  in  WIDTH+1  run-time modulus; 0 selects MODULUS.
- load  in  1  synchronous load strobe (only with MODN_LOAD_EN).
- load_val  in  WIDTH  load value (only with MODN_LOAD_EN).
- out  out  WIDTH  current count.
- tc  out  1  registered one-cycle wrap pulse.
- wrap_cnt  out  WRAP_W  saturating count of wraps since reset.

## Operation
- Effective modulus: M = (mod_val == 0) ? MODULUS : mod_val. Values above 2^WIDTH are clamped to 2^WIDTH.
- Priority per edge: clr > load > en. When none is active, all state holds and tc = 0.
- Up step: if out ≥ M−1, then out ← 0 and this is a wrap; else out ← out+1.
- Down step: if out == 0 or out > M−1, then out ← M−1. Only out == 0 counts as a wrap; the out > M−1 case is a silent clamp.
- M = 1: out stays 0 and every enabled step is a wrap.
- Out-of-range count (M shrunk mid-run below out+1):
  - An up step wraps to 0 and counts as a wrap.
  - A down step clamps to M−1 with no tc.
- Load: out ← min(load_val, M−1). tc ← 0; wrap_cnt is unchanged.
- tc is high in exactly the cycle after a wrapping step, i.e. coincident with out showing the wrapped value.
- wrap_cnt increments on each wrap and saturates at 2^WRAP_W−1.
- Direction change takes effect on the same edge it is sampled. No turnaround cycle.

## Timing
- Reset values: out = 0, tc = 0, wrap_cnt = 0, the cycle after clr is sampled high.
- clr mid-count overrides en and load on the same edge.
- Latency: en sampled at edge k → out updated after edge k. tc and wrap_cnt update on the same edge as out.
- mod_val is sampled every edge. A change applies to the step taken on that edge; no pipeline.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- MODN_LOAD_EN defined: load and load_val ports exist, with behaviour as above.
- MODN_LOAD_EN undefined: both ports are absent and the load priority level is removed. All other behaviour is identical.

## Structure
- Package modn_pkg:
  - typedef enum logic {DN = 0, UP = 1} dir_t;
  - function eff_mod(mod_val, MODULUS) returning the clamped M.
- Sub-module modn_step (combinational):
  - inputs: current count, M, dir.
  - outputs: next count and wrap flag.
  - Reused by the top level and by the bench's reference model.

## Test plan
- Reset and default modulus:
  - Stimulus: clr=1 for 2 cycles, then en=1, up=1, mod_val=0, for 12 cycles.
  - Response: out 0,1,2,3,4,0,1,…; tc high when out returns to 0; wrap_cnt = 2 after the 12th step.
- Down count:
  - Stimulus: mod_val=6, up=0, en=1 from out=0.
  - Response: out 5,4,3,2,1,0,5; tc high coincident with the first 5 and with the final 5.
- Modulus shrink mid-run:
  - Stimulus: out=6 at mod_val=8, then set mod_val=3.
  - Response, up: next out = 0 with tc=1.
  - Response, down: next out = 2 with tc=0.
- Load clamp (MODN_LOAD_EN defined):
  - Stimulus: mod_val=4, load=1, load_val=7, en=1.
  - Response: out = 3, tc = 0, wrap_cnt unchanged.
- Sync reset priority and saturation:
  - Stimulus: WRAP_W=2, M=2, drive 10 wraps.
  - Response: wrap_cnt saturates at 3.
  - Stimulus: clr=1 together with en and load.
  - Response: out=0, tc=0, wrap_cnt=0 on the next cycle.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared types and helpers for the mod-N counter: direction encoding and effective-modulus clamp.
// No state, no latency; pure definitions.
package modn_pkg;

  typedef enum logic {DN = 1'b0, UP = 1'b1} dir_t;

  // Returns M: zero selects the default modulus, anything above 2^width is pinned to 2^width.
  function automatic int unsigned eff_mod(input int unsigned mod_val,
                                          input int unsigned modulus,
                                          input int unsigned width);
    int unsigned cap;
    cap = 32'd1 << width;
    if (mod_val == 0)
      eff_mod = modulus;
    else if (mod_val > cap)
      eff_mod = cap;
    else
      eff_mod = mod_val;
  endfunction

endpackage

// File: rtl/modn_step.sv
// Combinational single-step rule for a mod-M counter in either direction; zero latency.
// No flow control: the caller decides whether the step is taken.
module modn_step
  import modn_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH:0]   m,
  input  dir_t             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] m_last;

  assign cnt_ext = {1'b0, cnt};
  assign m_last  = m - (WIDTH+1)'(1);

  always_comb begin
    nxt  = cnt;
    wrap = 1'b0;
    if (dir == UP) begin
      // A count left above M-1 by a shrinking modulus still wraps to zero.
      if (cnt_ext >= m_last) begin
        nxt  = '0;
        wrap = 1'b1;
      end else begin
        nxt = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        nxt  = m_last[WIDTH-1:0];
        wrap = 1'b1;
      end else if (cnt_ext > m_last) begin
        nxt = m_last[WIDTH-1:0];
      end else begin
        nxt = cnt - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modn_counter_param.sv
// Run-time mod-N up/down counter with registered wrap pulse and saturating wrap tally; one-cycle latency.
// No backpressure; priority clr > load > en. MODN_LOAD_EN adds the load/load_val ports.
module modn_counter_param
  import modn_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 5,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              up,
  input  logic [WIDTH:0]    mod_val,
`ifdef MODN_LOAD_EN
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
`endif
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] step_nxt;
  logic             step_wrap;
  dir_t             dir;

  assign m   = (WIDTH+1)'(eff_mod(32'(mod_val), MODULUS, WIDTH));
  assign dir = up ? UP : DN;

  modn_step #(.WIDTH(WIDTH)) u_step (
    .cnt  (out),
    .m    (m),
    .dir  (dir),
    .nxt  (step_nxt),
    .wrap (step_wrap)
  );

`ifdef MODN_LOAD_EN
  logic [WIDTH:0]   m_last;
  logic [WIDTH-1:0] load_clamped;

  assign m_last       = m - (WIDTH+1)'(1);
  assign load_clamped = ({1'b0, load_val} > m_last) ? m_last[WIDTH-1:0] : load_val;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      out      <= '0;
      tc       <= 1'b0;
      wrap_cnt <= '0;
`ifdef MODN_LOAD_EN
    end else if (load) begin
      out <= load_clamped;
      tc  <= 1'b0;
`endif
    end else if (en) begin
      out <= step_nxt;
      tc  <= step_wrap;
      if (step_wrap && (wrap_cnt != {WRAP_W{1'b1}}))
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_counter_param.sv
// Bench for modn_counter_param: directed vector table, multi-cycle corner sequences, randomized run vs. reference model.
// A second instance with a 2-bit tally shares the stimulus to exercise saturation.
module tb_modn_counter_param;

  localparam int WIDTH   = 3;
  localparam int MODULUS = 5;
  localparam int WRAP_W  = 8;
  localparam int CAP     = 1 << WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr, en, up;
  logic [WIDTH:0]    mod_val;
`ifdef MODN_LOAD_EN
  logic              load;
  logic [WIDTH-1:0]  load_val;
`endif
  logic [WIDTH-1:0]  out, out2;
  logic              tc, tc2;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [1:0]        wrap_cnt2;

  modn_counter_param #(.WIDTH(WIDTH), .MODULUS(MODULUS), .WRAP_W(WRAP_W)) u_dut (
    .clk(clk), .clr(clr), .en(en), .up(up), .mod_val(mod_val),
`ifdef MODN_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .out(out), .tc(tc), .wrap_cnt(wrap_cnt)
  );

  modn_counter_param #(.WIDTH(WIDTH), .MODULUS(MODULUS), .WRAP_W(2)) u_sat (
    .clk(clk), .clr(clr), .en(en), .up(up), .mod_val(mod_val),
`ifdef MODN_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .out(out2), .tc(tc2), .wrap_cnt(wrap_cnt2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v)
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    else
      n_pass++;
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  int m_out = 0, m_tc = 0, m_wraps = 0;

  task automatic model_edge();
    int m;
    int nxt;
    m = (mod_val == 0) ? MODULUS : ((int'(mod_val) > CAP) ? CAP : int'(mod_val));
    if (clr) begin
      m_out = 0; m_tc = 0; m_wraps = 0;
    end
`ifdef MODN_LOAD_EN
    else if (load) begin
      m_out = (int'(load_val) < m) ? int'(load_val) : m - 1;
      m_tc  = 0;
    end
`endif
    else if (en) begin
      m_tc = 0;
      if (up) begin
        nxt = m_out + 1;
        if (nxt >= m) begin m_out = 0; m_tc = 1; m_wraps++; end
        else m_out = nxt;
      end else begin
        if (m_out == 0) begin m_out = m - 1; m_tc = 1; m_wraps++; end
        else if (m_out >= m) m_out = m - 1;
        else m_out = m_out - 1;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  typedef struct {
    logic       clr, en, up;
    logic [3:0] mv;
    int         eout, etc, ewc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic c, input logic e, input logic u, input logic [3:0] mv,
                             input int eo, input int et, input int ew);
    vec_t r;
    r.clr = c; r.en = e; r.up = u; r.mv = mv; r.eout = eo; r.etc = et; r.ewc = ew;
    return r;
  endfunction

  initial begin
    int up_out[12];
    int dn_out[7];
    clr = 1'b1; en = 1'b0; up = 1'b1; mod_val = '0;
`ifdef MODN_LOAD_EN
    load = 1'b0; load_val = '0;
`endif

    // Default modulus count-up after a two-cycle reset.
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0));
    up_out = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
    for (int i = 0; i < 12; i++)
      tbl.push_back(v(0, 1, 1, 0, up_out[i], (up_out[i] == 0) ? 1 : 0, (i + 1) / 5));
    // clr beats en; then count down mod 6.
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0));
    dn_out = '{5, 4, 3, 2, 1, 0, 5};
    for (int i = 0; i < 7; i++)
      tbl.push_back(v(0, 1, 0, 6, dn_out[i], (i == 0 || i == 6) ? 1 : 0, (i == 6) ? 2 : 1));
    // Shrink modulus 8 -> 3 with out = 6, stepping up.
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) tbl.push_back(v(0, 1, 1, 8, i, 0, 0));
    tbl.push_back(v(0, 1, 1, 3, 0, 1, 1));
    tbl.push_back(v(0, 0, 1, 3, 0, 0, 1));
    // Same shrink, stepping down: silent clamp.
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) tbl.push_back(v(0, 1, 1, 8, i, 0, 0));
    tbl.push_back(v(0, 1, 0, 3, 2, 0, 0));
    tbl.push_back(v(0, 1, 0, 3, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 3, 1, 0, 0));
    // M = 1: every step wraps in both directions.
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++) tbl.push_back(v(0, 1, 1, 1, 0, 1, i));
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 4));
    // mod_val = 15 clamps to 8.
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 7; i++) tbl.push_back(v(0, 1, 1, 15, i, 0, 0));
    tbl.push_back(v(0, 1, 1, 15, 0, 1, 1));

    foreach (tbl[i]) begin
      clr = tbl[i].clr; en = tbl[i].en; up = tbl[i].up; mod_val = (WIDTH+1)'(tbl[i].mv);
      tick();
      chk($sformatf("vec%0d.out", i), 32'(out), tbl[i].eout);
      chk($sformatf("vec%0d.tc", i), 32'(tc), tbl[i].etc);
      chk($sformatf("vec%0d.wrap_cnt", i), 32'(wrap_cnt), tbl[i].ewc);
      chk($sformatf("vec%0d.wrap_cnt_w2", i), 32'(wrap_cnt2), sat(tbl[i].ewc, 3));
    end

    // Ten wraps at M = 2: the 2-bit tally pins at 3, the 8-bit one keeps counting.
    clr = 1'b1; en = 1'b0; tick();
    clr = 1'b0; en = 1'b1; up = 1'b1; mod_val = 2;
    for (int i = 0; i < 20; i++) tick();
    chk("sat.wrap_cnt_w2", 32'(wrap_cnt2), 3);
    chk("sat.wrap_cnt", 32'(wrap_cnt), 10);
    chk("sat.tc_on_wrap", 32'(tc), 1);

    // Drive the 8-bit tally to its ceiling with M = 1.
    mod_val = 1;
    for (int i = 0; i < 260; i++) tick();
    chk("sat8.wrap_cnt", 32'(wrap_cnt), 255);
    chk("sat8.out", 32'(out), 0);

`ifdef MODN_LOAD_EN
    // Load clamps to M-1, drops tc, leaves the tally alone.
    clr = 1'b1; en = 1'b0; tick();
    clr = 1'b0; en = 1'b1; up = 1'b1; mod_val = 2;
    tick(); tick();
    mod_val = 4; load = 1'b1; load_val = 7;
    tick();
    chk("load.out", 32'(out), 3);
    chk("load.tc", 32'(tc), 0);
    chk("load.wrap_cnt", 32'(wrap_cnt), 1);
    load = 1'b0;
    tick();
    chk("load.next_wrap", 32'(out), 0);
    load = 1'b1; clr = 1'b1;
`else
    clr = 1'b1;
`endif
    // clr together with en (and load when present).
    en = 1'b1;
    tick();
    chk("clr_pri.out", 32'(out), 0);
    chk("clr_pri.tc", 32'(tc), 0);
    chk("clr_pri.wrap_cnt", 32'(wrap_cnt), 0);
    chk("clr_pri.wrap_cnt_w2", 32'(wrap_cnt2), 0);
`ifdef MODN_LOAD_EN
    load = 1'b0;
`endif

    // Randomized run against the reference model.
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) mod_val = (WIDTH+1)'($urandom_range(0, 15));
`ifdef MODN_LOAD_EN
      load     = ($urandom_range(0, 15) == 0);
      load_val = WIDTH'($urandom_range(0, CAP - 1));
`endif
      tick();
      chk("rnd.out", 32'(out), m_out);
      chk("rnd.tc", 32'(tc), m_tc);
      chk("rnd.wrap_cnt", 32'(wrap_cnt), sat(m_wraps, 255));
      chk("rnd.wrap_cnt_w2", 32'(wrap_cnt2), sat(m_wraps, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
